// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
// Define MCTRL_ILLEGAL_TRAP_EN to trap undecoded opcodes in TRAP (adds illegal_op); otherwise they retire as NOPs.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       mem_err,
    output logic [3:0] state_o
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);
    localparam logic [3:0] TIMEOUT_MAX  = 4'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    logic       mem_err_q, mem_err_d;
    logic       mem_state_s;
    logic       mem_wait_s;
    logic       timeout_s;
    logic       fetch_ack_s;

    // A wait only counts in states that are actually talking to memory.
    assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_wait_s  = mem_state_s & ~mem_ready;
    assign timeout_s   = mem_wait_s & (cnt_q >= TIMEOUT_LAST);
    // Reset must never let a stray mem_ready load IR or PC.
    assign fetch_ack_s = mem_ready & rst_n;

    assign mem_err = mem_err_q;
    assign state_o = state_q;

    // State register, wait counter, opcode latch and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= 4'd0;
            op_q      <= 6'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state, opcode capture and wait-counter update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mem_err_d = mem_err_q | timeout_s;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
                    OP_RTYPE:                           state_d = S_R_EXEC;
                    OP_BEQ:                             state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    OP_ADDIU, OP_ORI, OP_ANDI, OP_LUI:  state_d = S_I_EXEC;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:                            state_d = S_TRAP;
`else
                    default:                            state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                if (op_q == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (op_q == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready || timeout_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase

        // A timed-out fetch stays in FETCH, so the counter saturates rather than clearing.
        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end else if (mem_wait_s && (cnt_q != TIMEOUT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath enables decoded from the current state.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal_op    = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = fetch_ack_s;
                pc_write  = fetch_ack_s;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ADDIU: alu_op = 3'b011;
                    OP_ORI:   alu_op = 3'b100;
                    OP_ANDI:  alu_op = 3'b101;
                    OP_LUI:   alu_op = 3'b110;
                    default:  alu_op = 3'b000;
                endcase
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core.
- Consumes the instruction opcode and a memory ready handshake.
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables.
- Produces the 3-bit alu_op code, which the downstream ALU-control decoder combines with funct to select the ALU operation.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in any memory state before mem_err asserts; 4-bit counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from the IR; sampled only in DECODE
- mem_ready  input  1  memory completed the current read or write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  regfile write data: 0=ALUOut, 1=MDR
- reg_dst  output  1  write register: 0=rt, 1=rd
- reg_write  output  1  regfile write enable
- alu_src_a  output  1  ALU A: 0=PC, 1=rs
- alu_src_b  output  2  ALU B: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- pc_source  output  2  PC input: 00=ALU result, 01=ALUOut, 10=jump target
- alu_op  output  3  000 add (lw/sw/PC+4), 001 sub (beq), 010 R-type by funct, 011 addiu, 100 ori, 101 andi, 110 lui
- mem_err  output  1  sticky memory timeout flag
- state_o  output  4  current state encoding, for debug

Behaviour:
- State register and wait counter reset asynchronously on rst_n=0.
- Reset state is FETCH; wait counter 0; mem_err 0.
- All outputs are decoded from the current state. Exception: ir_write, pc_write in FETCH, and the memory-state exits are qualified by mem_ready.
- Default output value is 0 unless listed for a state. Default alu_op is 000.
- During reset, outputs equal the FETCH values with mem_ready=0: mem_read=1, alu_src_b=01, all others 0.
- States, encoding in parentheses, with outputs and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00. If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
    - 100011 or 101011 -> MEM_ADDR
    - 000000 -> R_EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001001, 001101, 001100, 001111 -> I_EXEC
    - any other opcode -> ILLEGAL handling (see Optional Feature)
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=000. Go to MEM_RD if the latched opcode is lw, MEM_WR if sw.
  - MEM_RD(3): mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEM_WR(5): mem_write=1, i_or_d=1. On mem_ready go to FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=010. Go to R_WB.
  - R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - I_EXEC(8): alu_src_a=1, alu_src_b=10. alu_op is 011, 100, 101 or 110 for addiu, ori, andi, lui respectively. Go to I_WB.
  - I_WB(9): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Go to FETCH.
  - JUMP(11): pc_write=1, pc_source=10. Go to FETCH.
- Opcode latch: opcode is captured into an internal 6-bit register in DECODE. Later states use only the latched value.
- Memory timeout:
  - The wait counter increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - The counter clears on entering any state.
  - When the counter reaches MEM_TIMEOUT, mem_err is set (sticky until reset) and the FSM goes to FETCH. From MEM_WR and MEM_RD no write is performed.
  - In FETCH, a timeout restarts the fetch; the counter saturates and does not wrap.
- mem_ready asserted in a non-memory state is ignored.
- Reset asserted mid-instruction returns immediately to FETCH. No partial register or memory write is issued after rst_n falls.

Optional Feature:
- Macro: MCTRL_ILLEGAL_TRAP_EN.
- Defined: an undecoded opcode in DECODE enters TRAP(12). TRAP holds all enables 0 and asserts an extra 1-bit output illegal_op=1. The FSM stays in TRAP until reset.
- Undefined: an undecoded opcode is treated as a NOP (DECODE -> FETCH, no writes), and the illegal_op port does not exist.

Test Plan:
- Reset, then add R-type (opcode 000000) with mem_ready=1 every cycle -> states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7; alu_op=010 in state 6.
- lw (100011) with mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1 and i_or_d=1. MEM_WB then asserts reg_write=1 and mem_to_reg=1. Total of 5 states visited.
- ori (001101) then lui (001111) -> alu_op=100 in I_EXEC, then 110 in the next I_EXEC. Changing opcode after DECODE does not change alu_op.
- beq (000100) -> BRANCH state with pc_write_cond=1, alu_op=001, pc_source=01. pc_write stays 0.
- sw (101011) with mem_ready held 0 -> mem_err rises after 15 cycles in MEM_WR. FSM returns to FETCH and mem_write drops. mem_err remains 1 until rst_n pulses low.
- Opcode 111111 -> with MCTRL_ILLEGAL_TRAP_EN: state 12 and illegal_op=1 persistent. Without it: DECODE -> FETCH with no write enables asserted.
